usb_ep_ctrl: RTL

CPU-side controller for the USB endpoint buffers. Decodes the six USB endpoint registers on the 16-bit I/O bus (EP0 IN, EP0 OUT, EP1 IN; data and status each) and owns one byte FIFO per endpoint. It sequences packet hand-off between the CPU and the USB serial interface engine (SIE): arm, commit, retry/abort, and done flags. It sits between the I/O bus decoder and the SIE.

---
 rtl/usb_ep_ctrl.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/usb_ep_ctrl.sv
// usb_ep_ctrl: CPU-side controller for three USB endpoint byte FIFOs
// (EP0 IN, EP0 OUT, EP1 IN). Decodes six I/O registers at BASE+0..BASE+A
// and sequences packet hand-off to/from the SIE.
//   clk, reset          : single clock, synchronous active-high reset
//   io_addr/io_wr/io_rd : I/O bus access (exact 16-bit address match)
//   io_wdata/io_rdata   : write data / registered read data
//   ep0i_*, ep1i_*      : IN endpoint stream to the SIE plus done/retry pulses
//   ep0o_*              : OUT endpoint stream from the SIE plus done/setup/abort

// usb_ep_in: one IN endpoint FIFO with arm/done/retry packet control.
//   push/push_data       : CPU byte write to the DATA register
//   st_arm/st_clr/st_flush : decoded STATUS write bits
//   sie_*                : SIE-side stream and handshake
//   status               : STATUS register read value
module usb_ep_in #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [7:0]  push_data,
    input  logic        st_arm,
    input  logic        st_clr,
    input  logic        st_flush,
    input  logic        sie_ready,
    input  logic        sie_done,
    input  logic        sie_retry,
    output logic [7:0]  sie_data,
    output logic        sie_valid,
    output logic        sie_last,
    output logic        sie_armed,
    output logic [15:0] status
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] rd_ptr, wr_ptr, pkt_ptr;
    logic [PW-1:0] rd_nx, wr_nx, pkt_nx;
    logic [PW-1:0] occ;
    logic          armed, done_flag, armed_nx, done_nx;
    logic          full, pop, push_en;
    logic [7:0]    mem [DEPTH];

    assign occ       = wr_ptr - rd_ptr;
    assign full      = (occ == PW'(DEPTH));
    assign sie_valid = armed && (occ != '0);
    assign sie_last  = sie_valid && (occ == PW'(1));
    assign sie_armed = armed;
    // Masked so the SIE sees 0 whenever no byte is offered.
    assign sie_data  = sie_valid ? mem[rd_ptr[AW-1:0]] : '0;
    assign pop       = sie_valid && sie_ready;
    assign push_en   = push && !full && !armed;
    assign status    = {5'b0, full, done_flag, armed, 1'b0, 7'(occ)};

    // SIE events first, then the CPU status write (flush wins over all).
    always_comb begin
        rd_nx    = rd_ptr;
        wr_nx    = wr_ptr;
        pkt_nx   = pkt_ptr;
        armed_nx = armed;
        done_nx  = done_flag;
        if (pop)
            rd_nx = rd_ptr + PW'(1);
        if (sie_retry)
            rd_nx = pkt_ptr;
        if (sie_done) begin
            pkt_nx   = rd_nx;
            armed_nx = 1'b0;
            done_nx  = 1'b1;
        end
        if (push_en)
            wr_nx = wr_ptr + PW'(1);
        if (st_arm)
            armed_nx = 1'b1;
        if (st_clr)
            done_nx = 1'b0;
        if (st_flush) begin
            rd_nx    = '0;
            wr_nx    = '0;
            pkt_nx   = '0;
            armed_nx = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            pkt_ptr   <= '0;
            armed     <= 1'b0;
            done_flag <= 1'b0;
        end else begin
            rd_ptr    <= rd_nx;
            wr_ptr    <= wr_nx;
            pkt_ptr   <= pkt_nx;
            armed     <= armed_nx;
            done_flag <= done_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

module usb_ep_ctrl #(
    parameter logic [15:0] BASE  = 16'h5000,
    parameter int          DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] io_addr,
    input  logic        io_wr,
    input  logic        io_rd,
    input  logic [15:0] io_wdata,
    output logic [15:0] io_rdata,
    output logic [7:0]  ep0i_data,
    output logic        ep0i_valid,
    input  logic        ep0i_ready,
    output logic        ep0i_last,
    output logic        ep0i_armed,
    input  logic        ep0i_done,
    input  logic        ep0i_retry,
    output logic [7:0]  ep1i_data,
    output logic        ep1i_valid,
    input  logic        ep1i_ready,
    output logic        ep1i_last,
    output logic        ep1i_armed,
    input  logic        ep1i_done,
    input  logic        ep1i_retry,
    input  logic [7:0]  ep0o_data,
    input  logic        ep0o_valid,
    output logic        ep0o_ready,
    output logic        ep0o_armed,
    input  logic        ep0o_done,
    input  logic        ep0o_setup,
    input  logic        ep0o_abort
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [15:0] A_I0D = BASE;
    localparam logic [15:0] A_I0S = BASE + 16'h2;
    localparam logic [15:0] A_OD  = BASE + 16'h4;
    localparam logic [15:0] A_OS  = BASE + 16'h6;
    localparam logic [15:0] A_I1D = BASE + 16'h8;
    localparam logic [15:0] A_I1S = BASE + 16'hA;

    logic        wr_i0s, wr_os, wr_i1s;
    logic [15:0] st_i0, st_i1, st_o;
    logic [15:0] rdata_nx;
    logic        unused_wdata;

    assign wr_i0s = io_wr && (io_addr == A_I0S);
    assign wr_os  = io_wr && (io_addr == A_OS);
    assign wr_i1s = io_wr && (io_addr == A_I1S);
    assign unused_wdata = ^{io_wdata[15:12], io_wdata[10]};

    usb_ep_in #(.DEPTH(DEPTH)) u_ep0i (
        .clk       (clk),
        .reset     (reset),
        .push      (io_wr && (io_addr == A_I0D)),
        .push_data (io_wdata[7:0]),
        .st_arm    (wr_i0s && io_wdata[8]),
        .st_clr    (wr_i0s && io_wdata[9]),
        .st_flush  (wr_i0s && io_wdata[11]),
        .sie_ready (ep0i_ready),
        .sie_done  (ep0i_done),
        .sie_retry (ep0i_retry),
        .sie_data  (ep0i_data),
        .sie_valid (ep0i_valid),
        .sie_last  (ep0i_last),
        .sie_armed (ep0i_armed),
        .status    (st_i0)
    );

    usb_ep_in #(.DEPTH(DEPTH)) u_ep1i (
        .clk       (clk),
        .reset     (reset),
        .push      (io_wr && (io_addr == A_I1D)),
        .push_data (io_wdata[7:0]),
        .st_arm    (wr_i1s && io_wdata[8]),
        .st_clr    (wr_i1s && io_wdata[9]),
        .st_flush  (wr_i1s && io_wdata[11]),
        .sie_ready (ep1i_ready),
        .sie_done  (ep1i_done),
        .sie_retry (ep1i_retry),
        .sie_data  (ep1i_data),
        .sie_valid (ep1i_valid),
        .sie_last  (ep1i_last),
        .sie_armed (ep1i_armed),
        .status    (st_i1)
    );

    // EP0 OUT: SIE writes at wr_ptr, CPU reads committed bytes [rd_ptr, pkt_ptr).
    logic [PW-1:0] o_rd, o_wr, o_pkt, o_rd_nx, o_wr_nx, o_pkt_nx, o_cnt;
    logic          o_armed, o_done, o_setup, o_armed_nx, o_done_nx, o_setup_nx;
    logic          o_full, o_push, o_cpu_pop;
    logic [7:0]    o_mem [DEPTH];

    assign o_cnt      = o_pkt - o_rd;
    assign o_full     = ((o_wr - o_rd) == PW'(DEPTH));
    assign ep0o_ready = o_armed && !o_full;
    assign ep0o_armed = o_armed;
    assign o_push     = ep0o_valid && ep0o_ready;
    assign o_cpu_pop  = io_rd && (io_addr == A_OD) && (o_cnt != '0);
    assign st_o       = {5'b0, o_setup, o_done, o_armed, 1'b0, 7'(o_cnt)};

    always_comb begin
        o_rd_nx    = o_rd;
        o_wr_nx    = o_wr;
        o_pkt_nx   = o_pkt;
        o_armed_nx = o_armed;
        o_done_nx  = o_done;
        o_setup_nx = o_setup;
        if (o_push)
            o_wr_nx = o_wr + PW'(1);
        if (ep0o_abort)
            o_wr_nx = o_pkt;
        if (ep0o_done) begin
            o_pkt_nx   = o_wr_nx;
            o_armed_nx = 1'b0;
            o_done_nx  = 1'b1;
            o_setup_nx = ep0o_setup;
        end
        if (o_cpu_pop)
            o_rd_nx = o_rd + PW'(1);
        if (wr_os && io_wdata[8])
            o_armed_nx = 1'b1;
        if (wr_os && io_wdata[9]) begin
            o_done_nx  = 1'b0;
            o_setup_nx = 1'b0;
        end
        if (wr_os && io_wdata[11]) begin
            o_rd_nx    = '0;
            o_wr_nx    = '0;
            o_pkt_nx   = '0;
            o_armed_nx = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_rd    <= '0;
            o_wr    <= '0;
            o_pkt   <= '0;
            o_armed <= 1'b0;
            o_done  <= 1'b0;
            o_setup <= 1'b0;
        end else begin
            o_rd    <= o_rd_nx;
            o_wr    <= o_wr_nx;
            o_pkt   <= o_pkt_nx;
            o_armed <= o_armed_nx;
            o_done  <= o_done_nx;
            o_setup <= o_setup_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (o_push)
            o_mem[o_wr[AW-1:0]] <= ep0o_data;
    end

    always_comb begin
        rdata_nx = '0;
        if (io_rd) begin
            case (io_addr)
                A_I0S:   rdata_nx = st_i0;
                A_OS:    rdata_nx = st_o;
                A_I1S:   rdata_nx = st_i1;
                A_OD:    if (o_cnt != '0) rdata_nx = {8'h00, o_mem[o_rd[AW-1:0]]};
                default: rdata_nx = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            io_rdata <= '0;
        else
            io_rdata <= rdata_nx;
    end
endmodule
